// File: rtl/axis_pad_arbiter_pkg.sv
// Shared definitions for the AXI4-Stream pad arbiter: FSM encoding and the
// round-robin winner search used by the arbitration cycle.
package axis_pad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  // Largest supported source count; the search vector is sized for it.
  localparam int RR_MAX = 16;

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } rr_pick_t;

  // First requesting index at or after 'start', wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [3:0]        start,
                                       input int                n);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n && !res.vld) begin
        idx = (int'(start) + k) % n;
        if (req[idx]) begin
          res.vld = 1'b1;
          res.idx = 4'(idx);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_pad_arbiter_if.sv
// Bundle of the upstream (s_axis, packed per source) and downstream (m_axis)
// stream signals. The slave modport is the arbiter's view, the master modport
// is the view of the environment that feeds and drains it.
// Optional: AXIS_PAD_ARB_ID_EN adds m_axis_tid.
interface axis_pad_arbiter_if #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
`ifdef AXIS_PAD_ARB_ID_EN
  , parameter int ID_WIDTH = $clog2(S_COUNT)
`endif
);
  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [S_COUNT-1:0]            s_axis_tvalid;
  logic [S_COUNT-1:0]            s_axis_tready;
  logic [S_COUNT-1:0]            s_axis_tlast;
  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [USER_WIDTH-1:0]         m_axis_tuser;
`ifdef AXIS_PAD_ARB_ID_EN
  logic [ID_WIDTH-1:0]           m_axis_tid;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
    input  m_axis_tready
  );
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
    output m_axis_tready
  );
`else
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );
`endif
endinterface

// File: rtl/axis_pad_arb_skid.sv
// Two-entry skid register: output register plus one temp register. The
// input-side ready is registered (high while temp is empty), so a stall costs
// one extra beat landing in temp before ready drops.
module axis_pad_arb_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);
  logic             r_ready;
  logic             r_out_valid;
  logic             r_tmp_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_tmp_data;
  logic             w_accept;
  logic             w_out_load;
  logic             w_tmp_valid_next;

  assign w_accept   = i_valid && r_ready;
  assign w_out_load = !r_out_valid || i_ready;

  // Temp fills only when a beat arrives while the output register is stuck.
  always_comb begin
    w_tmp_valid_next = r_tmp_valid;
    if (w_out_load)
      w_tmp_valid_next = 1'b0;
    else if (w_accept)
      w_tmp_valid_next = 1'b1;
  end

  // Output/temp registers; temp drains into output before new input is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready     <= 1'b0;
      r_out_valid <= 1'b0;
      r_tmp_valid <= 1'b0;
      r_out_data  <= '0;
      r_tmp_data  <= '0;
    end else begin
      r_ready     <= !w_tmp_valid_next;
      r_tmp_valid <= w_tmp_valid_next;
      if (w_out_load) begin
        if (r_tmp_valid) begin
          r_out_data  <= r_tmp_data;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept)
            r_out_data <= i_data;
        end
      end else if (w_accept) begin
        r_tmp_data <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/axis_pad_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI4-Stream pad stage between
// S_COUNT sources, with a registered two-entry skid stage on the output.
// Optional: AXIS_PAD_ARB_ID_EN carries the granted index out on m_axis_tid.
module axis_pad_arbiter
  import axis_pad_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
`ifdef AXIS_PAD_ARB_ID_EN
  , parameter int ID_WIDTH = $clog2(S_COUNT)
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  axis_pad_arbiter_if.slave  bus,
  output logic [S_COUNT-1:0] grant,
  output logic               busy
);
  localparam int IDX_W = $clog2(S_COUNT);
`ifdef AXIS_PAD_ARB_ID_EN
  localparam int PW = ID_WIDTH + USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;
`else
  localparam int PW = USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [S_COUNT-1:0] r_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   r_last_idx;
  logic [RR_MAX-1:0]  w_req;
  logic [3:0]         w_start;
  rr_pick_t           w_pick;
  logic               w_src_valid;
  logic               w_src_last;
  logic               w_in_valid;
  logic               w_accept;
  logic               w_skid_ready;
  logic [PW-1:0]      w_in_payload;
  logic [PW-1:0]      w_out_payload;

  // Round-robin search starts one past the previous winner.
  always_comb begin
    w_req                = '0;
    w_req[S_COUNT-1:0]   = bus.s_axis_tvalid;
    w_start              = '0;
    if (r_last_idx != IDX_W'(S_COUNT - 1))
      w_start[IDX_W-1:0] = r_last_idx + 1'b1;
    w_pick = rr_pick(w_req, w_start, S_COUNT);
  end

  assign w_src_valid = bus.s_axis_tvalid[r_grant_idx];
  assign w_src_last  = bus.s_axis_tlast[r_grant_idx];
  assign w_in_valid  = (r_state == PASS) && w_src_valid;
  assign w_accept    = w_in_valid && w_skid_ready;

  // Only the granted source sees ready; everyone else is held off.
  always_comb begin
    bus.s_axis_tready = '0;
    if (r_state == PASS && w_skid_ready)
      bus.s_axis_tready[r_grant_idx] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // Next state: arbitrate in IDLE, leave PASS on the accepted tlast beat.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_pick.vld) w_state_next = PASS;
      PASS:    if (w_accept && w_src_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Grant bookkeeping: latch the winner, remember it as last at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_last_idx  <= IDX_W'(S_COUNT - 1);
    end else if (r_state == IDLE) begin
      if (w_pick.vld) begin
        r_grant_idx <= w_pick.idx[IDX_W-1:0];
        r_grant     <= S_COUNT'(1) << w_pick.idx;
      end
    end else if (w_accept && w_src_last) begin
      r_last_idx <= r_grant_idx;
      r_grant    <= '0;
    end
  end

`ifdef AXIS_PAD_ARB_ID_EN
  assign w_in_payload = {ID_WIDTH'(r_grant_idx),
                         bus.s_axis_tuser[r_grant_idx*USER_WIDTH +: USER_WIDTH],
                         w_src_last,
                         bus.s_axis_tkeep[r_grant_idx*KEEP_WIDTH +: KEEP_WIDTH],
                         bus.s_axis_tdata[r_grant_idx*DATA_WIDTH +: DATA_WIDTH]};
  assign {bus.m_axis_tid, bus.m_axis_tuser, bus.m_axis_tlast,
          bus.m_axis_tkeep, bus.m_axis_tdata} = w_out_payload;
`else
  assign w_in_payload = {bus.s_axis_tuser[r_grant_idx*USER_WIDTH +: USER_WIDTH],
                         w_src_last,
                         bus.s_axis_tkeep[r_grant_idx*KEEP_WIDTH +: KEEP_WIDTH],
                         bus.s_axis_tdata[r_grant_idx*DATA_WIDTH +: DATA_WIDTH]};
  assign {bus.m_axis_tuser, bus.m_axis_tlast,
          bus.m_axis_tkeep, bus.m_axis_tdata} = w_out_payload;
`endif

  axis_pad_arb_skid #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (w_in_payload),
    .i_valid (w_in_valid),
    .o_ready (w_skid_ready),
    .o_data  (w_out_payload),
    .o_valid (bus.m_axis_tvalid),
    .i_ready (bus.m_axis_tready)
  );

  assign grant = r_grant;
  assign busy  = (r_state == PASS);

endmodule
